core_mem_responder: RTL



---
 rtl/core_mem_pkg.sv | 20 ++
 rtl/core_mem_responder_if.sv | 35 +++
 rtl/core_mem_array.sv | 40 ++++
 rtl/core_mem_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_mem_pkg                                                               |
// | Shared types and constants for the core memory responder.                  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package core_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_rsp_state_t;

  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
  localparam int          NUM_LANES = 4;

endpackage

`default_nettype wire

// File: rtl/core_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_mem_responder_if                                                      |
// | Request/response bus between the arbiter (master) and responder (slave).   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface core_mem_responder_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import core_mem_pkg::*;

  logic                 req_read;
  logic                 req_write;
  logic [AW-1:0]        req_addr;
  logic [NUM_LANES-1:0] req_byte_en;
  logic [DW-1:0]        req_data;
  logic                 req_ready;
  logic                 rsp_ack;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_err;

  modport master (
    output req_read, req_write, req_addr, req_byte_en, req_data,
    input  req_ready, rsp_ack, rsp_data, rsp_err
  );

  modport slave (
    input  req_read, req_write, req_addr, req_byte_en, req_data,
    output req_ready, rsp_ack, rsp_data, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/core_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_mem_array                                                             |
// | Single-port byte-lane RAM, registered read, no reset (block-RAM friendly). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module core_mem_array
  import core_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  wire logic                 i_clk,
  input  wire logic                 i_en,
  input  wire logic [NUM_LANES-1:0] i_we,
  input  wire logic [IDX_W-1:0]     i_addr,
  input  wire logic [31:0]          i_wdata,
  output logic      [31:0]          o_rdata
);

  // One narrow array per lane keeps each lane a plain inferable RAM.
  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_q;

    always_ff @(posedge i_clk) begin
      if (i_en) begin
        if (i_we[n]) begin
          r_mem[i_addr] <= i_wdata[8*n +: 8];
        end
        r_q <= r_mem[i_addr];
      end
    end

    assign o_rdata[8*n +: 8] = r_q;
  end

endmodule

`default_nettype wire

// File: rtl/core_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_mem_responder                                                         |
// | Memory target behind core_mem_arbiter: one access at a time, optional      |
// | wait states, single-cycle ack. Define CORE_MEM_RESPONDER_ERR_EN to flag    |
// | out-of-range word indices instead of wrapping them.                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input wire logic            i_clk,
  input wire logic            i_rst,
  input wire logic            i_clk_en,
  core_mem_responder_if.slave bus
);

  localparam int         c_idx_w     = $clog2(DEPTH_WORDS);
  localparam bit         c_no_wait   = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_rsp_state_t       r_state;
  mem_rsp_state_t       w_state_nxt;
  logic [3:0]           r_wait_cnt;
  logic [3:0]           w_wait_cnt_nxt;
  logic                 w_accept;
  logic                 w_access;

  logic [AW-1:0]        r_addr;
  logic [NUM_LANES-1:0] r_be;
  logic [DW-1:0]        r_wdata;
  logic                 r_write;
  logic                 r_rsp_read;

  logic                 w_from_bus;
  logic [AW-1:0]        w_acc_addr;
  logic [NUM_LANES-1:0] w_acc_be;
  logic [DW-1:0]        w_acc_wdata;
  logic                 w_acc_write;
  logic                 w_acc_err;
  logic [DW-1:0]        w_ram_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else if (i_clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_access       = 1'b0;
    w_accept       = (r_state != WAIT) && (bus.req_read || bus.req_write);
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          if (c_no_wait) begin
            w_access    = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_wait_cnt_nxt = c_wait_load;
            w_state_nxt    = WAIT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Zero-wait accesses use the live bus; delayed ones use the latched copy.
  assign w_from_bus  = (r_state != WAIT);
  assign w_acc_addr  = w_from_bus ? bus.req_addr    : r_addr;
  assign w_acc_be    = w_from_bus ? bus.req_byte_en : r_be;
  assign w_acc_wdata = w_from_bus ? bus.req_data    : r_wdata;
  assign w_acc_write = w_from_bus ? bus.req_write   : r_write;

`ifdef CORE_MEM_RESPONDER_ERR_EN
  logic w_unused_addr;
  logic r_rsp_err;
  assign w_acc_err     = |w_acc_addr[AW-1:c_idx_w+2];
  assign w_unused_addr = ^w_acc_addr[1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_err <= 1'b0;
    end else if (i_clk_en && w_access) begin
      r_rsp_err <= w_acc_err;
    end
  end

  assign bus.rsp_err  = (r_state == RESP) && r_rsp_err;
  assign bus.rsp_data = ((r_state == RESP) && r_rsp_read) ?
                        (r_rsp_err ? ERR_DATA : w_ram_rdata) : '0;
`else
  logic w_unused_addr;
  assign w_acc_err     = 1'b0;
  assign w_unused_addr = ^{w_acc_addr[1:0], w_acc_addr[AW-1:c_idx_w+2]};
  assign bus.rsp_err   = 1'b0;
  assign bus.rsp_data  = ((r_state == RESP) && r_rsp_read) ? w_ram_rdata : '0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt <= 4'd0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_rsp_read <= 1'b0;
    end else if (i_clk_en) begin
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_be    <= bus.req_byte_en;
        r_wdata <= bus.req_data;
        r_write <= bus.req_write;
      end
      if (w_access) begin
        r_rsp_read <= ~w_acc_write;
      end
    end
  end

  core_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_idx_w)
  ) u_array (
    .i_clk   (i_clk),
    .i_en    (w_access && i_clk_en),
    .i_we    ({NUM_LANES{w_acc_write && !w_acc_err}} & w_acc_be),
    .i_addr  (w_acc_addr[c_idx_w+1:2]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.req_ready = (r_state != WAIT);
  assign bus.rsp_ack   = (r_state == RESP);

endmodule

`default_nettype wire
